// File: rtl/sub16_pipe_if.sv
// rtl/sub16_pipe_if.sv - operand/result handshake bundle for sub16_pipe
interface sub16_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, borrow, overflow
    );
endinterface

// File: rtl/sub16_pipe.sv
// rtl/sub16_pipe.sv - two-stage prefix-network subtractor, diff = a - b - bin
// Optional build macro SUB16_SAT_EN clamps diff on signed overflow.
module sub16_pipe #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    sub16_pipe_if.slave  bus
);
    localparam int H = WIDTH / 2;

    // Kogge-Stone add of one half; returns {carry_out, sum}
    function automatic logic [H:0] prefix_add(
        input logic [H-1:0] x,
        input logic [H-1:0] y,
        input logic         cin
    );
        logic [H-1:0] p;
        logic [H-1:0] g;
        logic [H-1:0] gp;
        logic [H-1:0] gn;
        logic [H-1:0] pn;
        p    = x ^ y;
        g    = x & y;
        g[0] = g[0] | (p[0] & cin);
        gp   = p;
        for (int d = 1; d < H; d = d * 2) begin
            gn = g;
            pn = gp;
            for (int i = d; i < H; i++) begin
                gn[i] = g[i] | (gp[i] & g[i-d]);
                pn[i] = gp[i] & gp[i-d];
            end
            g  = gn;
            gp = pn;
        end
        return {g[H-1], p ^ {g[H-2:0], cin}};
    endfunction

    logic             s1_valid;
    logic [H-1:0]     s1_lo;
    logic             s1_carry;
    logic [H-1:0]     s1_a_hi;
    logic [H-1:0]     s1_nb_hi;
    logic             s1_a_msb;
    logic             s1_b_msb;

    logic             s2_valid;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;

    logic             s2_stall;
    logic [H:0]       lo_res;
    logic [H:0]       hi_res;
    logic [WIDTH-1:0] full;
    logic             ovf;
    logic [WIDTH-1:0] res;

    assign s2_stall     = s2_valid && !bus.out_ready;
    assign bus.in_ready = !s1_valid || !s2_stall;

    always_comb begin
        lo_res = prefix_add(bus.a[H-1:0], ~bus.b[H-1:0], ~bus.bin);
        hi_res = prefix_add(s1_a_hi, s1_nb_hi, s1_carry);
        full   = {hi_res[H-1:0], s1_lo};
        ovf    = (s1_a_msb != s1_b_msb) && (full[WIDTH-1] != s1_a_msb);
`ifdef SUB16_SAT_EN
        if (ovf) begin
            res = s1_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res = full;
        end
`else
        res = full;
`endif
    end

    // Operand capture only happens on accept, so held data never changes under a stall
    always_ff @(posedge clk) begin
        if (bus.in_ready && bus.in_valid) begin
            s1_lo    <= lo_res[H-1:0];
            s1_carry <= lo_res[H];
            s1_a_hi  <= bus.a[WIDTH-1:H];
            s1_nb_hi <= ~bus.b[WIDTH-1:H];
            s1_a_msb <= bus.a[WIDTH-1];
            s1_b_msb <= bus.b[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (!s2_stall) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    diff_q   <= res;
                    borrow_q <= ~hi_res[H];
                    ovf_q    <= ovf;
                end
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.overflow  = ovf_q;
endmodule
